// File: rtl/c64_mem_map_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// c64_mem_map_if: 6502 core address/data bus as seen by the memory map.
// Rev 1.0
// ---------------------------------------------------------------------------
interface c64_mem_map_if;
   logic [15:0] cpu_ab;
   logic        cpu_we;
   logic [7:0]  cpu_do;
   logic [7:0]  cpu_di;

   modport master (output cpu_ab, output cpu_we, output cpu_do, input cpu_di);
   modport slave  (input cpu_ab, input cpu_we, input cpu_do, output cpu_di);
endinterface
`default_nettype wire

// File: rtl/c64_mem_map.sv
`default_nettype none
// ---------------------------------------------------------------------------
// c64_mem_map: C64 address decoder plus 6510 $00/$01 I/O port; read data muxed
// one cycle after the address. Define C64MM_CART_EN to add cartridge ROML/ROMH.
// Rev 1.0
// ---------------------------------------------------------------------------
module c64_mem_map #(
   parameter logic [7:0] DDR_RESET  = 8'h00,
   parameter logic [7:0] DATA_RESET = 8'h00
) (
   input  wire         clk,
   input  wire         reset,
   c64_mem_map_if.slave cpu,
   output logic [15:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  wire  [7:0]  ram_rdata,
   output logic [12:0] basic_addr,
   input  wire  [7:0]  basic_rdata,
   output logic [12:0] kernal_addr,
   input  wire  [7:0]  kernal_rdata,
   output logic [11:0] char_addr,
   input  wire  [7:0]  char_rdata,
   output logic        io_cs,
   output logic        io_we,
   input  wire  [7:0]  io_rdata,
`ifdef C64MM_CART_EN
   input  wire         exrom,
   input  wire         game,
   input  wire  [7:0]  cart_rdata,
   output logic        roml_cs,
   output logic        romh_cs,
`endif
   input  wire  [7:0]  port_in,
   output logic [7:0]  port_out
);

   localparam logic [2:0] c_RAM    = 3'd0;
   localparam logic [2:0] c_PORT   = 3'd1;
   localparam logic [2:0] c_BASIC  = 3'd2;
   localparam logic [2:0] c_KERNAL = 3'd3;
   localparam logic [2:0] c_CHAR   = 3'd4;
   localparam logic [2:0] c_IO     = 3'd5;
   localparam logic [2:0] c_ROML   = 3'd6;
   localparam logic [2:0] c_ROMH   = 3'd7;

   logic [7:0] r_ddr;
   logic [7:0] r_data;
   logic [2:0] r_sel;
   logic [7:0] r_port_rd;

   logic       w_loram;
   logic       w_hiram;
   logic       w_charen;
   logic       w_exrom;
   logic       w_game;
   logic [2:0] w_region;
   logic       w_port_hit;
   logic       w_io_vis;

   assign port_out = (r_data & r_ddr) | (port_in & ~r_ddr);
   assign w_loram  = port_out[0];
   assign w_hiram  = port_out[1];
   assign w_charen = port_out[2];

`ifdef C64MM_CART_EN
   // Ultimax (GAME=0, EXROM=1) collapses to the no-cartridge map.
   assign w_exrom = exrom;
   assign w_game  = game | exrom;
`else
   assign w_exrom = 1'b1;
   assign w_game  = 1'b1;
`endif

   assign w_port_hit = (cpu.cpu_ab[15:1] == 15'd0);

   always_comb begin
      w_region = c_RAM;
      if (w_port_hit) begin
         w_region = c_PORT;
      end else begin
         case (cpu.cpu_ab[15:12])
            4'h8, 4'h9: if (!w_exrom && w_loram && w_hiram) w_region = c_ROML;
            4'hA, 4'hB: begin
               if (!w_exrom && !w_game && w_hiram) w_region = c_ROMH;
               else if (w_loram && w_hiram)        w_region = c_BASIC;
            end
            4'hD: if (w_loram || w_hiram) w_region = w_charen ? c_IO : c_CHAR;
            4'hE, 4'hF: if (w_hiram) w_region = c_KERNAL;
            default: w_region = c_RAM;
         endcase
      end
   end

   assign w_io_vis = (w_region == c_IO);

   assign ram_addr    = cpu.cpu_ab;
   assign ram_wdata   = cpu.cpu_do;
   assign basic_addr  = cpu.cpu_ab[12:0];
   assign kernal_addr = cpu.cpu_ab[12:0];
   assign char_addr   = cpu.cpu_ab[11:0];

   // Strobes are gated by the async reset so an aborted access never writes.
   assign io_cs  = ~reset & w_io_vis;
   assign io_we  = ~reset & w_io_vis & cpu.cpu_we;
   assign ram_we = ~reset & ~w_io_vis & cpu.cpu_we;

`ifdef C64MM_CART_EN
   assign roml_cs = ~reset & ~cpu.cpu_we & (w_region == c_ROML);
   assign romh_cs = ~reset & ~cpu.cpu_we & (w_region == c_ROMH);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ddr     <= DDR_RESET;
         r_data    <= DATA_RESET;
         r_sel     <= c_RAM;
         r_port_rd <= 8'h00;
      end else begin
         r_sel     <= w_region;
         // Pre-write register value is what a port read returns.
         r_port_rd <= cpu.cpu_ab[0] ? r_data : r_ddr;
         if (cpu.cpu_we && w_port_hit) begin
            if (cpu.cpu_ab[0]) r_data <= cpu.cpu_do;
            else               r_ddr  <= cpu.cpu_do;
         end
      end
   end

   always_comb begin
      cpu.cpu_di = ram_rdata;
      case (r_sel)
         c_PORT:   cpu.cpu_di = r_port_rd;
         c_BASIC:  cpu.cpu_di = basic_rdata;
         c_KERNAL: cpu.cpu_di = kernal_rdata;
         c_CHAR:   cpu.cpu_di = char_rdata;
         c_IO:     cpu.cpu_di = io_rdata;
`ifdef C64MM_CART_EN
         c_ROML, c_ROMH: cpu.cpu_di = cart_rdata;
`endif
         default:  cpu.cpu_di = ram_rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_c64_mem_map.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_c64_mem_map: directed and random bus traffic against a behavioural map model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_c64_mem_map;

   localparam int K_RAM = 0, K_PORT = 1, K_BASIC = 2, K_KERNAL = 3, K_CHAR = 4, K_IO = 5;

   logic        clk;
   logic        reset;
   logic [15:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic [12:0] basic_addr;
   logic [7:0]  basic_rdata;
   logic [12:0] kernal_addr;
   logic [7:0]  kernal_rdata;
   logic [11:0] char_addr;
   logic [7:0]  char_rdata;
   logic        io_cs;
   logic        io_we;
   logic [7:0]  io_rdata;
   logic [7:0]  port_in;
   logic [7:0]  port_out;

   int n_chk  = 0;
   int n_fail = 0;

   c64_mem_map_if bus ();

   c64_mem_map dut (
      .clk          (clk),
      .reset        (reset),
      .cpu          (bus.slave),
      .ram_addr     (ram_addr),
      .ram_we       (ram_we),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata),
      .basic_addr   (basic_addr),
      .basic_rdata  (basic_rdata),
      .kernal_addr  (kernal_addr),
      .kernal_rdata (kernal_rdata),
      .char_addr    (char_addr),
      .char_rdata   (char_rdata),
      .io_cs        (io_cs),
      .io_we        (io_we),
      .io_rdata     (io_rdata),
      .port_in      (port_in),
      .port_out     (port_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Pin level per bit: driven by the data register where DDR is output.
   function automatic logic [7:0] pins_of(input logic [7:0] ddr, input logic [7:0] dat,
                                          input logic [7:0] ext);
      logic [7:0] p;
      for (int b = 0; b < 8; b++) p[b] = ddr[b] ? dat[b] : ext[b];
      return p;
   endfunction

   function automatic int region_of(input logic [15:0] a, input logic [7:0] pins);
      logic lo, hi, ch;
      lo = pins[0];
      hi = pins[1];
      ch = pins[2];
      if (a <= 16'h0001) return K_PORT;
      if (a >= 16'hA000 && a <= 16'hBFFF) return (lo && hi) ? K_BASIC : K_RAM;
      if (a >= 16'hD000 && a <= 16'hDFFF) begin
         if (!lo && !hi) return K_RAM;
         return ch ? K_IO : K_CHAR;
      end
      if (a >= 16'hE000) return hi ? K_KERNAL : K_RAM;
      return K_RAM;
   endfunction

   // Model state, updated at the same edges as the design.
   logic [7:0] m_ddr, m_data, m_port_val;
   int         m_kind;
   logic       m_rd_valid;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_ddr      <= 8'h00;
         m_data     <= 8'h00;
         m_port_val <= 8'h00;
         m_kind     <= K_RAM;
         m_rd_valid <= 1'b1;
      end else begin
         m_kind     <= region_of(bus.cpu_ab, pins_of(m_ddr, m_data, port_in));
         m_port_val <= bus.cpu_ab[0] ? m_data : m_ddr;
         m_rd_valid <= !bus.cpu_we;
         if (bus.cpu_we && bus.cpu_ab == 16'h0000) m_ddr  <= bus.cpu_do;
         if (bus.cpu_we && bus.cpu_ab == 16'h0001) m_data <= bus.cpu_do;
      end
   end

   always @(negedge clk) begin
      logic [7:0]  pins;
      int          kind;
      logic        io_vis;
      logic [7:0]  exp_di;
      #2;
      pins   = pins_of(m_ddr, m_data, port_in);
      kind   = region_of(bus.cpu_ab, pins);
      io_vis = (kind == K_IO);
      chk("port_out", {8'h00, port_out}, {8'h00, pins});
      chk("io_cs",  {15'd0, io_cs},  {15'd0, !reset && io_vis});
      chk("io_we",  {15'd0, io_we},  {15'd0, !reset && io_vis && bus.cpu_we});
      chk("ram_we", {15'd0, ram_we}, {15'd0, !reset && !io_vis && bus.cpu_we});
      chk("ram_addr", ram_addr, bus.cpu_ab);
      chk("ram_wdata", {8'h00, ram_wdata}, {8'h00, bus.cpu_do});
      chk("rom_addr", {basic_addr[12], kernal_addr[12:0], char_addr[11:10]},
          {bus.cpu_ab[12], bus.cpu_ab[12:0], bus.cpu_ab[11:10]});
      if (m_rd_valid) begin
         case (m_kind)
            K_PORT:   exp_di = m_port_val;
            K_BASIC:  exp_di = basic_rdata;
            K_KERNAL: exp_di = kernal_rdata;
            K_CHAR:   exp_di = char_rdata;
            K_IO:     exp_di = io_rdata;
            default:  exp_di = ram_rdata;
         endcase
         chk("cpu_di", {8'h00, bus.cpu_di}, {8'h00, exp_di});
      end
   end

   task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d);
      @(negedge clk);
      reset      = 1'b0;
      bus.cpu_ab = a;
      bus.cpu_we = w;
      bus.cpu_do = d;
      #3;
   endtask

   initial begin
      reset        = 1'b1;
      bus.cpu_ab   = 16'h0002;
      bus.cpu_we   = 1'b0;
      bus.cpu_do   = 8'h00;
      port_in      = 8'hFF;
      ram_rdata    = 8'h5A;
      basic_rdata  = 8'hB1;
      kernal_rdata = 8'hE1;
      char_rdata   = 8'hC1;
      io_rdata     = 8'hD1;
      repeat (2) @(negedge clk);

      // Default map after reset: BASIC and KERNAL visible.
      step(16'hA000, 1'b0, 8'h00);
      chk("t1_port_out", {8'h00, port_out}, 16'h00FF);
      step(16'hE000, 1'b0, 8'h00);
      chk("t1_basic", {8'h00, bus.cpu_di}, 16'h00B1);
      step(16'h0002, 1'b0, 8'h00);
      chk("t1_kernal", {8'h00, bus.cpu_di}, 16'h00E1);

      // All-RAM map.
      step(16'h0000, 1'b1, 8'h2F);
      step(16'h0001, 1'b1, 8'h34);
      step(16'hA000, 1'b0, 8'h00);
      chk("t2_port_out", {8'h00, port_out}, 16'h00F4);
      step(16'hD000, 1'b0, 8'h00);
      chk("t2_a000", {8'h00, bus.cpu_di}, 16'h005A);
      chk("t2_io_cs", {15'd0, io_cs}, 16'h0000);
      step(16'hE000, 1'b0, 8'h00);
      chk("t2_d000", {8'h00, bus.cpu_di}, 16'h005A);
      step(16'h0002, 1'b0, 8'h00);
      chk("t2_e000", {8'h00, bus.cpu_di}, 16'h005A);

      // I/O visible.
      step(16'h0001, 1'b1, 8'h37);
      step(16'hD020, 1'b1, 8'h06);
      chk("t3_io_cs", {15'd0, io_cs}, 16'h0001);
      chk("t3_io_we", {15'd0, io_we}, 16'h0001);
      chk("t3_ram_we", {15'd0, ram_we}, 16'h0000);
      step(16'hD020, 1'b0, 8'h00);
      step(16'h0002, 1'b0, 8'h00);
      chk("t3_io_rd", {8'h00, bus.cpu_di}, 16'h00D1);

      // CHAR ROM, then LORAM cleared.
      step(16'h0001, 1'b1, 8'h33);
      step(16'hD000, 1'b0, 8'h00);
      step(16'h0001, 1'b1, 8'h36);
      chk("t4_char", {8'h00, bus.cpu_di}, 16'h00C1);
      step(16'hA000, 1'b0, 8'h00);
      step(16'h0002, 1'b0, 8'h00);
      chk("t4_ram", {8'h00, bus.cpu_di}, 16'h005A);

      // Port as all inputs.
      step(16'h0001, 1'b1, 8'h00);
      step(16'h0000, 1'b1, 8'h00);
      port_in = 8'h15;
      step(16'h0001, 1'b0, 8'h00);
      chk("t5_port_out", {8'h00, port_out}, 16'h0015);
      step(16'hA000, 1'b0, 8'h00);
      chk("t5_data_rd", {8'h00, bus.cpu_di}, 16'h0000);
      step(16'h0002, 1'b0, 8'h00);
      chk("t5_a000_ram", {8'h00, bus.cpu_di}, 16'h005A);

      // Reset during a write to $0001.
      port_in = 8'hFF;
      step(16'h0001, 1'b1, 8'h07);
      reset = 1'b1;
      #1;
      chk("t6_ram_we", {15'd0, ram_we}, 16'h0000);
      step(16'h0001, 1'b0, 8'h00);
      chk("t6_di_ram", {8'h00, bus.cpu_di}, 16'h005A);
      step(16'h0002, 1'b0, 8'h00);
      chk("t6_data_rst", {8'h00, bus.cpu_di}, 16'h0000);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         logic [15:0] a;
         logic        w;
         case ($urandom_range(0, 6))
            0:       a = 16'($urandom_range(0, 1));
            1:       a = 16'hA000 + 16'($urandom_range(0, 16'h1FFF));
            2:       a = 16'hD000 + 16'($urandom_range(0, 16'h0FFF));
            3:       a = 16'hE000 + 16'($urandom_range(0, 16'h1FFF));
            4:       a = 16'h8000 + 16'($urandom_range(0, 16'h1FFF));
            default: a = 16'($urandom);
         endcase
         w = ($urandom_range(0, 3) == 0);
         port_in      = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         ram_rdata    = 8'($urandom);
         basic_rdata  = 8'($urandom);
         kernal_rdata = 8'($urandom);
         char_rdata   = 8'($urandom);
         io_rdata     = 8'($urandom);
         step(a, w, 8'($urandom));
         if ($urandom_range(0, 149) == 0) reset = 1'b1;
      end

      step(16'h0002, 1'b0, 8'h00);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
